cadence_gen: RTL and testbench

- Programmable pedal-cadence stimulus generator: the transmit-side counterpart of the cadence period measurement path.
- Produces a 50%-duty square wave whose period is set by an 8-bit period code. The code uses the same scaling as the measured cadence period: code × 2^SHIFT clocks.
- Used to drive the cadence input of the eBike sensor chain in simulation and in on-chip self-test.
- Period changes take effect only at cycle boundaries. Stopping always completes the current cycle, so no runt pulses are produced.

---
 rtl/cadence_gen.sv | 102 ++++++++++
 tb/tb_cadence_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cadence_gen.sv
// Programmable cadence square-wave generator: 50% duty, period = code << SHIFT.
// Period/enable are only sampled at cycle boundaries, so no runt pulses occur.
module cadence_gen #(
   parameter bit FAST_SIM = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] cadence_per,
   output logic       cadence,
   output logic       cadence_rise,
   output logic       pedaling,
   output logic [7:0] cycle_cnt
);

   localparam int SHIFT = FAST_SIM ? 7 : 16;

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t      r_state;
   state_t      w_state_nx;
   logic [23:0] r_cnt;
   logic [23:0] w_cnt_nx;
   logic [23:0] w_half;
   logic [7:0]  r_per;
   logic [7:0]  r_cycle;
   logic        r_cadence;
   logic        r_rise;
   logic        r_ped;
   logic        w_go;
   logic        w_last;
   logic        w_start;

   assign w_half = {16'd0, r_per} << (SHIFT - 1);
   assign w_last = (r_cnt == w_half - 24'd1);
   assign w_go   = en && (cadence_per != 8'd0);

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt + 24'd1;
      w_start    = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_cnt_nx = 24'd0;
            if (w_go) begin
               w_start    = 1'b1;
               w_state_nx = HIGH;
            end
         end
         HIGH: begin
            if (w_last) begin
               w_cnt_nx   = 24'd0;
               w_state_nx = LOW;
            end
         end
         LOW: begin
            // end of cycle: the only point where en/code are honoured
            if (w_last) begin
               w_cnt_nx = 24'd0;
               if (w_go) begin
                  w_start    = 1'b1;
                  w_state_nx = HIGH;
               end else begin
                  w_state_nx = IDLE;
               end
            end
         end
         default: begin
            w_cnt_nx   = 24'd0;
            w_state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= 24'd0;
         r_per     <= 8'd0;
         r_cycle   <= 8'd0;
         r_cadence <= 1'b0;
         r_rise    <= 1'b0;
         r_ped     <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_cadence <= (w_state_nx == HIGH);
         r_rise    <= w_start;
         r_ped     <= (w_state_nx != IDLE);
         if (w_start) begin
            r_per   <= cadence_per;
            r_cycle <= r_cycle + 8'd1;
         end
      end
   end

   assign cadence      = r_cadence;
   assign cadence_rise = r_rise;
   assign pedaling     = r_ped;
   assign cycle_cnt    = r_cycle;

endmodule

// File: tb/tb_cadence_gen.sv
// Scoreboard bench for cadence_gen: stimulus queues expected cycle records,
// a monitor measures each generated cycle and checks it against the queue.
module tb_cadence_gen;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] cadence_per;
   logic       cadence;
   logic       cadence_rise;
   logic       pedaling;
   logic [7:0] cycle_cnt;

   cadence_gen #(.FAST_SIM(1'b1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .cadence_per  (cadence_per),
      .cadence      (cadence),
      .cadence_rise (cadence_rise),
      .pedaling     (pedaling),
      .cycle_cnt    (cycle_cnt)
   );

   typedef struct {
      int cnt;
      int hi;
      int lo;
      int idle_end;
   } rec_t;

   rec_t q[$];
   int   checks = 0;
   int   errors = 0;

   int   ms;
   int   m_hi;
   int   m_lo;
   int   m_cnt;
   int   m_prev_rise;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic push(input int c, input int h, input int l, input int ie);
      rec_t r;
      r.cnt = c;
      r.hi = h;
      r.lo = l;
      r.idle_end = ie;
      q.push_back(r);
   endtask

   task automatic finish_rec(input int c, input int h, input int l,
                             input int ie);
      rec_t e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_cycle actual=cnt%0d required=none", c);
      end else begin
         e = q.pop_front();
         chk("cyc_cnt", c, e.cnt);
         chk("cyc_high", h, e.hi);
         chk("cyc_low", l, e.lo);
         chk("cyc_idle_end", ie, e.idle_end);
      end
   endtask

   // monitor: measures high/low length of each cycle between rises
   initial begin
      ms = 0;
      m_hi = 0;
      m_lo = 0;
      m_cnt = 0;
      m_prev_rise = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ms = 0;
            m_prev_rise = 0;
         end else if (cadence_rise) begin
            chk("rise_twice", m_prev_rise, 0);
            chk("rise_cad", int'(cadence), 1);
            chk("rise_ped", int'(pedaling), 1);
            if (ms == 2) finish_rec(m_cnt, m_hi, m_lo, 0);
            m_cnt = int'(cycle_cnt);
            m_hi = 1;
            m_lo = 0;
            ms = 1;
         end else if (ms == 1) begin
            if (cadence) m_hi++;
            else begin
               m_lo = 1;
               ms = 2;
            end
         end else if (ms == 2) begin
            if (!pedaling) begin
               finish_rec(m_cnt, m_hi, m_lo, 1);
               ms = 0;
            end else if (!cadence) begin
               m_lo++;
            end
         end
         m_prev_rise = rst_n ? int'(cadence_rise) : 0;
      end
   end

   task automatic wait_rise(input int n, input int budget);
      int seen = 0;
      int t = 0;
      while (seen < n && t < budget) begin
         @(negedge clk);
         t++;
         if (cadence_rise) seen++;
      end
      if (seen < n) begin
         checks++;
         errors++;
         $display("FAIL wait_rise_timeout actual=%0d required=%0d", seen, n);
      end
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      @(negedge clk);
      while (pedaling && t < budget) begin
         @(negedge clk);
         t++;
      end
      if (pedaling) begin
         checks++;
         errors++;
         $display("FAIL wait_idle_timeout actual=1 required=0");
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b0;
      cadence_per = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_cad", int'(cadence), 0);
      chk("rst_rise", int'(cadence_rise), 0);
      chk("rst_ped", int'(pedaling), 0);
      chk("rst_cnt", int'(cycle_cnt), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_cad", int'(cadence), 0);

      // 1: basic run, code 1 -> 64 high / 64 low
      push(1, 64, 64, 0);
      push(2, 64, 64, 0);
      push(3, 64, 64, 1);
      en = 1'b1;
      cadence_per = 8'd1;
      @(negedge clk);
      chk("t1_first_cad", int'(cadence), 1);
      chk("t1_first_rise", int'(cadence_rise), 1);
      chk("t1_first_ped", int'(pedaling), 1);
      chk("t1_first_cnt", int'(cycle_cnt), 1);
      @(negedge clk);
      chk("t1_rise_pulse", int'(cadence_rise), 0);
      wait_rise(2, 400);
      en = 1'b0;
      wait_idle(300);
      repeat (20) @(negedge clk);
      chk("t1_idle_cad", int'(cadence), 0);

      // 2: period change mid-HIGH applies to the next cycle only
      push(4, 128, 128, 0);
      push(5, 256, 256, 1);
      en = 1'b1;
      cadence_per = 8'd2;
      wait_rise(1, 20);
      repeat (10) @(negedge clk);
      cadence_per = 8'd4;
      wait_rise(1, 400);
      en = 1'b0;
      wait_idle(700);

      // 3: stop 10 clocks into HIGH completes the cycle
      push(6, 192, 192, 1);
      en = 1'b1;
      cadence_per = 8'd3;
      wait_rise(1, 20);
      repeat (9) @(negedge clk);
      en = 1'b0;
      wait_idle(450);
      repeat (300) @(negedge clk);
      chk("t3_cad", int'(cadence), 0);
      chk("t3_ped", int'(pedaling), 0);
      chk("t3_cnt", int'(cycle_cnt), 6);

      // 4: zero code holds IDLE; code 1 then starts at once
      en = 1'b1;
      cadence_per = 8'd0;
      do_reset();
      repeat (500) @(negedge clk);
      chk("t4_cad", int'(cadence), 0);
      chk("t4_ped", int'(pedaling), 0);
      chk("t4_cnt", int'(cycle_cnt), 0);
      push(1, 64, 64, 1);
      cadence_per = 8'd1;
      @(negedge clk);
      chk("t4_start_cad", int'(cadence), 1);
      en = 1'b0;
      wait_idle(200);

      // 5: async reset mid-HIGH of cycle 5
      push(2, 64, 64, 0);
      push(3, 64, 64, 0);
      push(4, 64, 64, 0);
      en = 1'b1;
      cadence_per = 8'd1;
      wait_rise(4, 600);
      repeat (5) @(negedge clk);
      chk("t5_pre_cnt", int'(cycle_cnt), 5);
      chk("t5_pre_cad", int'(cadence), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_async_cad", int'(cadence), 0);
      chk("t5_async_ped", int'(pedaling), 0);
      chk("t5_async_cnt", int'(cycle_cnt), 0);
      chk("t5_async_rise", int'(cadence_rise), 0);
      repeat (2) @(negedge clk);
      push(1, 64, 64, 1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_restart_cnt", int'(cycle_cnt), 1);
      chk("t5_restart_cad", int'(cadence), 1);
      en = 1'b0;
      wait_idle(200);

      // 6: wrap to 0 on a max-period cycle
      do_reset();
      for (int i = 1; i <= 255; i++) push(i, 64, 64, 0);
      push(0, 16320, 16320, 1);
      en = 1'b1;
      cadence_per = 8'd1;
      wait_rise(255, 255 * 128 + 50);
      cadence_per = 8'd255;
      wait_rise(1, 200);
      chk("t6_wrap_cnt", int'(cycle_cnt), 0);
      en = 1'b0;
      wait_idle(33000);
      repeat (5) @(negedge clk);

      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
